// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared definitions for the instruction fetch stage of the 16-bit core:
//   default widths, reset PC, prefetch depth, the buffer occupancy encoding
//   and a helper that advances the occupancy state for one clock.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  // Default instruction / address width in bits.
  localparam int unsigned FETCH_L        = 16;
  // Default PC loaded on reset.
  localparam logic [15:0] FETCH_RESET_PC = 16'h0000;
  // Prefetch buffer depth; the buffer is built for exactly two entries.
  localparam int unsigned FETCH_DEPTH    = 2;

  // Prefetch buffer occupancy.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Next occupancy for a given push/pop pair (flush is handled by the caller).
  // push and pop together leave the occupancy unchanged. The caller is
  // expected to qualify push with room and pop with non-empty.
  function automatic occ_e occ_step(input occ_e occ, input logic push, input logic pop);
    occ_e nxt;
    nxt = occ;
    case (occ)
      OCC_EMPTY: if (push) nxt = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop) nxt = OCC_FULL;
        else if (pop && !push) nxt = OCC_EMPTY;
      end
      OCC_FULL: if (pop && !push) nxt = OCC_ONE;
      default: nxt = OCC_EMPTY;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_unit_buffer.sv
// -----------------------------------------------------------------------------
// fetch_unit_buffer
//   Two-entry synchronous FIFO holding {pc, instr} pairs between the PC /
//   memory side and decode. Flush empties the FIFO and has priority over push.
//   The head is presented from registered storage only; it reads as zero
//   while the FIFO is empty so stale entries never leak out.
//
// Ports
//   clk        in   core clock
//   reset      in   synchronous active-high reset; clears entries and pointers
//   push       in   write push_data at the tail (ignored if full without pop)
//   pop        in   retire the head (ignored when empty)
//   flush      in   discard all entries; beats push and pop
//   push_data  in   W-bit entry to write
//   head_valid out  FIFO holds at least one entry
//   head_data  out  W-bit head entry (zero while empty)
//   occ        out  current occupancy
// -----------------------------------------------------------------------------
module fetch_unit_buffer
  import fetch_unit_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] push_data,
  output logic         head_valid,
  output logic [W-1:0] head_data,
  output occ_e         occ
);

  occ_e occ_q, occ_d;
  logic rd_ptr_q, rd_ptr_d;
  logic wr_ptr_q, wr_ptr_d;

  logic pop_ok;
  logic push_ok;
  logic [1:0] wr_en;
  logic [W-1:0] entry_rd [2];

  // Pop only retires something real; push needs a free slot, which a
  // same-cycle pop provides when full.
  assign pop_ok  = pop & (occ_q != OCC_EMPTY);
  assign push_ok = push & ~flush & ((occ_q != OCC_FULL) | pop_ok);

  // One storage register per entry, written only when the tail points at it.
  for (genvar gi = 0; gi < 2; gi++) begin : gen_entry
    logic [W-1:0] data_q;

    assign wr_en[gi] = push_ok & (wr_ptr_q == 1'(gi));

    always_ff @(posedge clk) begin
      if (reset) begin
        data_q <= '0;
      end else if (wr_en[gi]) begin
        data_q <= push_data;
      end
    end

    assign entry_rd[gi] = data_q;
  end

  always_comb begin
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      // Pointers return to slot 0 so the next fill starts from a known place.
      occ_d    = OCC_EMPTY;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      occ_d = occ_step(occ_q, push_ok, pop_ok);
      if (push_ok) wr_ptr_d = ~wr_ptr_q;
      if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
    end
  end

  // Occupancy state machine and pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q    <= OCC_EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign occ        = occ_q;
  assign head_valid = (occ_q != OCC_EMPTY);
  assign head_data  = head_valid ? entry_rd[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage of the 16-bit core. Owns the word-addressed PC,
//   drives it straight to instruction memory (combinational read) and
//   captures each {pc, instruction} pair in a two-entry prefetch buffer that
//   decode drains over a valid/ready handshake. A taken branch/jump redirect
//   reloads the PC and flushes the buffer.
//
// Ports
//   clk             in   core clock
//   reset           in   synchronous active-high reset
//   fetch_en        in   1 = new fetches allowed; buffer drains regardless
//   imem_addr       out  word address to instruction memory (= pc)
//   imem_instr      in   instruction read combinationally at imem_addr
//   if_valid        out  buffer head holds a valid instruction
//   if_instr        out  instruction at buffer head
//   if_pc           out  PC of instruction at buffer head
//   id_ready        in   decode accepts the head this cycle
//   redirect_valid  in   branch/jump taken; load redirect_pc
//   redirect_pc     in   redirect target word address
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned   L        = FETCH_L,
  parameter logic [L-1:0]  RESET_PC = L'(FETCH_RESET_PC),
  parameter int unsigned   DEPTH    = FETCH_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fetch_en,
  output logic [L-1:0] imem_addr,
  input  logic [L-1:0] imem_instr,
  output logic         if_valid,
  output logic [L-1:0] if_instr,
  output logic [L-1:0] if_pc,
  input  logic         id_ready,
  input  logic         redirect_valid,
  input  logic [L-1:0] redirect_pc
);

  logic [L-1:0]   pc_q, pc_d;
  logic           pop;
  logic           room;
  logic           push;
  logic [2*L-1:0] head_data;
  occ_e           buf_occ;

  // Decode consumes the head even in a redirect cycle; the flush only
  // discards what is left behind.
  assign pop  = if_valid & id_ready;

  // A slot is free either because the buffer is not full or because the
  // head leaves this cycle.
  assign room = (32'(buf_occ) < DEPTH) | pop;

  // Redirect suppresses the fetch: the word at the old pc is on the wrong path.
  assign push = fetch_en & ~redirect_valid & room;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (push) begin
      // Wraps modulo 2^L.
      pc_d = pc_q + L'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_unit_buffer #(
    .W (2*L)
  ) u_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_data  ({pc_q, imem_instr}),
    .head_valid (if_valid),
    .head_data  (head_data),
    .occ        (buf_occ)
  );

  assign imem_addr = pc_q;
  assign if_pc     = head_data[2*L-1:L];
  assign if_instr  = head_data[L-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        id_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;

  int tests = 0;
  int failed = 0;

  // Instruction memory: random contents, combinational read.
  logic [15:0] imem [0:65535];
  assign imem_instr = imem[imem_addr];

  always #5 clk = ~clk;

  fetch_unit #(.L(16), .RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  ent_t        exp_q[$];
  int          m_cnt = 0;
  logic [15:0] m_pc = 16'h0000;
  bit          m_live = 1'b0;

  // Model: at each rising edge apply the fetch rules to the inputs in force.
  always @(posedge clk) begin
    bit m_pop, m_push;
    if (reset) begin
      exp_q.delete();
      m_cnt  = 0;
      m_pc   = 16'h0000;
      m_live = 1'b1;
    end else if (m_live) begin
      m_pop = (m_cnt > 0) && id_ready;
      if (redirect_valid) begin
        exp_q.delete();
        m_cnt = 0;
        m_pc  = redirect_pc;
      end else begin
        m_push = fetch_en && ((m_cnt < 2) || m_pop);
        m_cnt  = m_cnt - int'(m_pop) + int'(m_push);
        if (m_push) begin
          exp_q.push_back('{pc: m_pc, instr: imem[m_pc]});
          m_pc = m_pc + 16'd1;
        end
      end
    end
  end

  // Monitor: on the falling edge compare what the DUT presents, pop on handshake.
  always @(negedge clk) begin
    if (m_live) begin
      check("valid", {31'b0, if_valid}, {31'b0, exp_q.size() != 0});
      check("imem_addr", {16'b0, imem_addr}, {16'b0, m_pc});
      if (if_valid && exp_q.size() != 0) begin
        check("head", {if_pc, if_instr}, {exp_q[0].pc, exp_q[0].instr});
        if (id_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 65536; a++) imem[a] = 16'($urandom);

    // 1: reset, then free-running fetch
    repeat (2) cyc();
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_pc", {16'b0, if_pc}, 32'd0);
    check("rst_instr", {16'b0, if_instr}, 32'd0);
    check("rst_addr", {16'b0, imem_addr}, 32'd0);
    reset = 1'b0; fetch_en = 1'b1; id_ready = 1'b1;
    cyc();
    check("t1_valid", {31'b0, if_valid}, 32'd1);
    check("t1_pc0", {16'b0, if_pc}, 32'd0);
    check("t1_instr0", {16'b0, if_instr}, {16'b0, imem[0]});
    for (int i = 1; i < 4; i++) begin
      cyc();
      check("t1_pc_seq", {16'b0, if_pc}, 32'(i));
    end

    // 2: decode stalls, buffer fills, then drains in order
    reset = 1'b1; cyc();
    reset = 1'b0; id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t2_hold_pc", {16'b0, if_pc}, 32'd0);
      check("t2_hold_instr", {16'b0, if_instr}, {16'b0, imem[0]});
    end
    check("t2_pc_stop", {16'b0, imem_addr}, 32'd2);
    id_ready = 1'b1;
    cyc(); check("t2_drain1", {16'b0, if_pc}, 32'd1);
    cyc(); check("t2_drain2", {16'b0, if_pc}, 32'd2);

    // 3: redirect while full
    id_ready = 1'b0;
    repeat (2) cyc();
    redirect_valid = 1'b1; redirect_pc = 16'h0020;
    cyc();
    redirect_valid = 1'b0;
    check("t3_bubble", {31'b0, if_valid}, 32'd0);
    cyc();
    check("t3_valid", {31'b0, if_valid}, 32'd1);
    check("t3_target", {16'b0, if_pc}, 32'h20);

    // 4: redirect with simultaneous pop at count 1, then fetch disabled
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0040;
    cyc();
    redirect_valid = 1'b0; fetch_en = 1'b0;
    check("t4_flushed", {31'b0, if_valid}, 32'd0);
    check("t4_pc", {16'b0, imem_addr}, 32'h40);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t4_pc_held", {16'b0, imem_addr}, 32'h40);
      check("t4_empty", {31'b0, if_valid}, 32'd0);
    end

    // 5: wrap-around at the top of the address space
    fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    cyc();
    redirect_valid = 1'b0;
    cyc(); check("t5_ffff", {16'b0, if_pc}, 32'hFFFF);
    cyc(); check("t5_0000", {16'b0, if_pc}, 32'h0000);
    cyc(); check("t5_0001", {16'b0, if_pc}, 32'h0001);

    // 6: reset while full
    id_ready = 1'b0;
    repeat (2) cyc();
    id_ready = 1'b1; reset = 1'b1;
    cyc();
    check("t6_valid", {31'b0, if_valid}, 32'd0);
    check("t6_pc", {16'b0, if_pc}, 32'd0);
    check("t6_addr", {16'b0, imem_addr}, 32'd0);
    reset = 1'b0;
    cyc();
    check("t6_resume", {31'b0, if_valid}, 32'd1);
    check("t6_resume_pc", {16'b0, if_pc}, 32'd0);

    // Random traffic checked by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 199) == 0);
      fetch_en       = ($urandom_range(0, 9) < 8);
      id_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF))
                                                   : 16'($urandom);
      cyc();
    end
    reset = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b0; id_ready = 1'b1;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
